phase_arbiter: RTL and testbench

PHASE_ARBITER -- requirements
Module: phase_arbiter

---
 rtl/traffic_pkg.sv | 71 +++++++
 rtl/phase_timer.sv | 36 +++
 rtl/phase_arbiter.sv | 134 +++++++++++++
 tb/tb_phase_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the phase arbiter: lamp encodings, the phase
// state enum, the timing-config struct and the clearance-end selector.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    // Internal width of timing thresholds; config inputs are zero-extended to this.
    localparam int CFG_W = 16;

    typedef enum logic [2:0] {
        GREEN_A = 3'd0,
        YEL_A   = 3'd1,
        RED_A   = 3'd2,
        GREEN_B = 3'd3,
        YEL_B   = 3'd4,
        RED_B   = 3'd5,
        WALK    = 3'd6,
        RED_W   = 3'd7
    } phase_t;

    typedef struct packed {
        logic [CFG_W-1:0] min_green;
        logic [CFG_W-1:0] max_green;
        logic [CFG_W-1:0] yellow_t;
        logic [CFG_W-1:0] allred_t;
        logic [CFG_W-1:0] walk_t;
    } timing_cfg_t;

    // A programmed duration of 0 behaves as 1 tick.
    function automatic logic [CFG_W-1:0] fix_zero(input logic [CFG_W-1:0] v);
        return (v == '0) ? CFG_W'(1) : v;
    endfunction

    // Next service phase at the end of an all-red clearance. Emergency wins
    // (A over B); otherwise round-robin starting after the phase just served,
    // falling back to GREEN_A when nothing is pending.
    function automatic phase_t next_green(input phase_t cleared,
                                          input logic pa, input logic pb,
                                          input logic pp, input logic ea,
                                          input logic eb);
        phase_t n;
        n = GREEN_A;
        if (ea)      n = GREEN_A;
        else if (eb) n = GREEN_B;
        else begin
            case (cleared)
                RED_A: begin
                    if (pb)      n = GREEN_B;
                    else if (pp) n = WALK;
                    else         n = GREEN_A;
                end
                RED_B: begin
                    if (pp)      n = WALK;
                    else if (pa) n = GREEN_A;
                    else if (pb) n = GREEN_B;
                    else         n = GREEN_A;
                end
                default: begin
                    if (pa)      n = GREEN_A;
                    else if (pb) n = GREEN_B;
                    else if (pp) n = WALK;
                    else         n = GREEN_A;
                end
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-state tick counter: clears on state change, counts ticks, saturates,
// and compares the elapsed tick count (count + 1) against two thresholds.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int TW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_tick,
    input  logic [CFG_W-1:0] i_n0,
    input  logic [CFG_W-1:0] i_n1,
    output logic             o_ge0,
    output logic             o_ge1
);

    logic [TW-1:0] r_count;
    logic [CFG_W:0] w_elapsed;

    // Clear wins over tick; hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_tick && (r_count != '1)) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign w_elapsed = (CFG_W+1)'(r_count) + (CFG_W+1)'(1);
    assign o_ge0     = (w_elapsed >= {1'b0, i_n0});
    assign o_ge1     = (w_elapsed >= {1'b0, i_n1});

endmodule

// File: rtl/phase_arbiter.sv
// Two-road intersection arbiter with pedestrian phase and emergency preempt.
// All durations are counted in ticks; lamp outputs decode from registers only.
module phase_arbiter
    import traffic_pkg::*;
#(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          req_p,
    input  logic [1:0]    emerg,
    input  logic [TW-1:0] min_green,
    input  logic [TW-1:0] max_green,
    input  logic [TW-1:0] yellow_t,
    input  logic [TW-1:0] allred_t,
    input  logic [TW-1:0] walk_t,
    output logic [2:0]    road_a,
    output logic [2:0]    road_b,
    output logic          walk,
    output logic          preempt,
    output logic [2:0]    phase
);

    phase_t           r_state;
    phase_t           w_next;
    logic             r_pend_a, r_pend_b, r_pend_p;
    logic [1:0]       r_pend_e;
    logic             r_preempt;
    timing_cfg_t      w_cfg;
    logic [CFG_W-1:0] w_n0;
    logic             w_ge0, w_ge1, w_ea, w_eb, w_clr;

    assign w_cfg = '{min_green: fix_zero(CFG_W'(min_green)),
                     max_green: fix_zero(CFG_W'(max_green)),
                     yellow_t:  fix_zero(CFG_W'(yellow_t)),
                     allred_t:  fix_zero(CFG_W'(allred_t)),
                     walk_t:    fix_zero(CFG_W'(walk_t))};

    // Emergency requests are latched so a short pulse still steers clearance.
    assign w_ea  = emerg[0] | r_pend_e[0];
    assign w_eb  = emerg[1] | r_pend_e[1];
    assign w_clr = (w_next != r_state);

    phase_timer #(.TW(TW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_tick (tick),
        .i_n0   (w_n0),
        .i_n1   (w_cfg.max_green),
        .o_ge0  (w_ge0),
        .o_ge1  (w_ge1)
    );

    // Next-state and per-state duration select; transitions only on a tick.
    always_comb begin
        w_next = r_state;
        w_n0   = w_cfg.allred_t;
        case (r_state)
            GREEN_A: begin
                w_n0 = w_cfg.min_green;
                if (tick && !emerg[0] &&
                    (w_eb || ((r_pend_b || r_pend_p) && ((w_ge0 && !req_a) || w_ge1))))
                    w_next = YEL_A;
            end
            GREEN_B: begin
                w_n0 = w_cfg.min_green;
                if (tick && (w_ea || (!emerg[1] && (r_pend_a || r_pend_p) &&
                                      ((w_ge0 && !req_b) || w_ge1))))
                    w_next = YEL_B;
            end
            YEL_A: begin
                w_n0 = w_cfg.yellow_t;
                if (tick && w_ge0) w_next = RED_A;
            end
            YEL_B: begin
                w_n0 = w_cfg.yellow_t;
                if (tick && w_ge0) w_next = RED_B;
            end
            WALK: begin
                w_n0 = w_cfg.walk_t;
                if (tick && (w_ea || w_eb || w_ge0)) w_next = RED_W;
            end
            RED_A, RED_B, RED_W: begin
                if (tick && w_ge0)
                    w_next = next_green(r_state, r_pend_a, r_pend_b, r_pend_p, w_ea, w_eb);
            end
            default: w_next = GREEN_A;
        endcase
    end

    // State, pending flags (clear on phase entry beats set) and preempt flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= GREEN_A;
            r_pend_a  <= 1'b0;
            r_pend_b  <= 1'b0;
            r_pend_p  <= 1'b0;
            r_pend_e  <= 2'b00;
            r_preempt <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pend_a    <= (w_next == GREEN_A && r_state != GREEN_A) ? 1'b0 : (r_pend_a | req_a);
            r_pend_b    <= (w_next == GREEN_B && r_state != GREEN_B) ? 1'b0 : (r_pend_b | req_b);
            r_pend_p    <= (w_next == WALK && r_state != WALK) ? 1'b0 : (r_pend_p | req_p);
            r_pend_e[0] <= (w_next == GREEN_A) ? 1'b0 : (r_pend_e[0] | emerg[0]);
            r_pend_e[1] <= (w_next == GREEN_B) ? 1'b0 : (r_pend_e[1] | emerg[1]);
            r_preempt   <= (w_next == GREEN_A && emerg[0]) ||
                           (w_next == GREEN_B && emerg[1] && !emerg[0]);
        end
    end

    // Lamp decode from the state register.
    always_comb begin
        road_a = RED;
        road_b = RED;
        walk   = 1'b0;
        case (r_state)
            GREEN_A: road_a = GREEN;
            YEL_A:   road_a = YELLOW;
            GREEN_B: road_b = GREEN;
            YEL_B:   road_b = YELLOW;
            WALK:    walk   = 1'b1;
            default: ;
        endcase
    end

    assign preempt = r_preempt;
    assign phase   = r_state;

endmodule

// File: tb/tb_phase_arbiter.sv
// Directed bench for phase_arbiter; expected lamp/phase vectors are hand-derived.
module tb_phase_arbiter;

    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_G = 3'b001;
    localparam logic [2:0] P_GA = 3'd0, P_YA = 3'd1, P_RA = 3'd2, P_GB = 3'd3;
    localparam logic [2:0] P_YB = 3'd4, P_RB = 3'd5, P_WK = 3'd6, P_RW = 3'd7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0, req_p = 1'b0;
    logic [1:0] emerg = 2'b00;
    logic [3:0] min_green = 4'd3, max_green = 4'd8, yellow_t = 4'd2;
    logic [3:0] allred_t = 4'd1, walk_t = 4'd4;
    logic [2:0] road_a, road_b, phase;
    logic       walk, preempt;

    int checks = 0;
    int errors = 0;

    // {road_a, road_b, walk, preempt, phase}
    wire [10:0] obs = {road_a, road_b, walk, preempt, phase};

    phase_arbiter #(.TW(4)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .req_a(req_a), .req_b(req_b), .req_p(req_p), .emerg(emerg),
        .min_green(min_green), .max_green(max_green), .yellow_t(yellow_t),
        .allred_t(allred_t), .walk_t(walk_t),
        .road_a(road_a), .road_b(road_b), .walk(walk), .preempt(preempt),
        .phase(phase)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic step_tick();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; req_p = 1'b0; emerg = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== {L_G, L_R, 1'b0, 1'b0, P_GA}) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", obs, {L_G, L_R, 1'b0, 1'b0, P_GA});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_idle_rest();
        do_reset();
        for (int t = 1; t <= 30; t++) begin
            step_tick();
            checks++;
            if (obs !== {L_G, L_R, 1'b0, 1'b0, P_GA}) begin
                errors++;
                $display("FAIL idle_rest t=%0d got %b exp %b", t, obs, {L_G, L_R, 1'b0, 1'b0, P_GA});
            end
        end
    endtask

    task automatic test_min_green();
        logic [10:0] exp;
        do_reset();
        req_b = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            step_tick();
            req_b = 1'b0;
            case (t)
                1, 2:    exp = {L_G, L_R, 1'b0, 1'b0, P_GA};
                3, 4:    exp = {L_Y, L_R, 1'b0, 1'b0, P_YA};
                5:       exp = {L_R, L_R, 1'b0, 1'b0, P_RA};
                default: exp = {L_R, L_G, 1'b0, 1'b0, P_GB};
            endcase
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL min_green t=%0d got %b exp %b", t, obs, exp);
            end
        end
    endtask

    task automatic test_max_green_walk();
        logic [10:0] exp;
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        for (int t = 1; t <= 22; t++) begin
            step_tick();
            if (t == 1) req_b = 1'b0;
            if (t == 12) req_p = 1'b0;
            if (t <= 7)       exp = {L_G, L_R, 1'b0, 1'b0, P_GA};
            else if (t <= 9)  exp = {L_Y, L_R, 1'b0, 1'b0, P_YA};
            else if (t == 10) exp = {L_R, L_R, 1'b0, 1'b0, P_RA};
            else if (t <= 13) exp = {L_R, L_G, 1'b0, 1'b0, P_GB};
            else if (t <= 15) exp = {L_R, L_Y, 1'b0, 1'b0, P_YB};
            else if (t == 16) exp = {L_R, L_R, 1'b0, 1'b0, P_RB};
            else if (t <= 20) exp = {L_R, L_R, 1'b1, 1'b0, P_WK};
            else if (t == 21) exp = {L_R, L_R, 1'b0, 1'b0, P_RW};
            else              exp = {L_G, L_R, 1'b0, 1'b0, P_GA};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL max_green_walk t=%0d got %b exp %b", t, obs, exp);
            end
            if (t == 11) begin
                req_a = 1'b0;
                req_p = 1'b1;
            end
        end
    endtask

    task automatic test_emerg_b();
        logic [10:0] exp;
        do_reset();
        for (int t = 1; t <= 16; t++) begin
            step_tick();
            if (t == 6) req_a = 1'b0;
            if (t == 1)       exp = {L_G, L_R, 1'b0, 1'b0, P_GA};
            else if (t <= 3)  exp = {L_Y, L_R, 1'b0, 1'b0, P_YA};
            else if (t == 4)  exp = {L_R, L_R, 1'b0, 1'b0, P_RA};
            else if (t <= 15) exp = {L_R, L_G, 1'b0, 1'b1, P_GB};
            else              exp = {L_R, L_Y, 1'b0, 1'b0, P_YB};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL emerg_b t=%0d got %b exp %b", t, obs, exp);
            end
            if (t == 1) emerg = 2'b10;
            if (t == 5) req_a = 1'b1;
            if (t == 15) emerg = 2'b00;
        end
    endtask

    task automatic test_emerg_both();
        logic [10:0] exp;
        do_reset();
        req_b = 1'b1;
        emerg = 2'b11;
        for (int t = 1; t <= 14; t++) begin
            step_tick();
            req_b = 1'b0;
            if (t <= 10)      exp = {L_G, L_R, 1'b0, 1'b1, P_GA};
            else if (t <= 12) exp = {L_Y, L_R, 1'b0, 1'b0, P_YA};
            else if (t == 13) exp = {L_R, L_R, 1'b0, 1'b0, P_RA};
            else              exp = {L_R, L_G, 1'b0, 1'b0, P_GB};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL emerg_both t=%0d got %b exp %b", t, obs, exp);
            end
            if (t == 10) emerg = 2'b00;
        end
    endtask

    task automatic test_zero_cfg();
        logic [10:0] exp;
        do_reset();
        min_green = 4'd0;
        yellow_t  = 4'd0;
        req_b = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            step_tick();
            req_b = 1'b0;
            case (t)
                1:       exp = {L_Y, L_R, 1'b0, 1'b0, P_YA};
                2:       exp = {L_R, L_R, 1'b0, 1'b0, P_RA};
                default: exp = {L_R, L_G, 1'b0, 1'b0, P_GB};
            endcase
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL zero_cfg t=%0d got %b exp %b", t, obs, exp);
            end
        end
        min_green = 4'd3;
        yellow_t  = 4'd2;
    endtask

    task automatic test_reset_mid_phase();
        do_reset();
        req_b = 1'b1;
        step_tick();
        req_b = 1'b0;
        req_p = 1'b1;
        step_tick();
        req_p = 1'b0;
        step_tick();
        checks++;
        if (obs !== {L_Y, L_R, 1'b0, 1'b0, P_YA}) begin
            errors++;
            $display("FAIL mid_reset_pre got %b exp %b", obs, {L_Y, L_R, 1'b0, 1'b0, P_YA});
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== {L_G, L_R, 1'b0, 1'b0, P_GA}) begin
            errors++;
            $display("FAIL mid_reset_now got %b exp %b", obs, {L_G, L_R, 1'b0, 1'b0, P_GA});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            step_tick();
            checks++;
            if (obs !== {L_G, L_R, 1'b0, 1'b0, P_GA}) begin
                errors++;
                $display("FAIL mid_reset_pend t=%0d got %b exp %b", t, obs, {L_G, L_R, 1'b0, 1'b0, P_GA});
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_rest();
        test_min_green();
        test_max_green_walk();
        test_emerg_b();
        test_emerg_both();
        test_zero_cfg();
        test_reset_mid_phase();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
